pipe_hold_ctrl: RTL and testbench

Central pipeline hold/flush controller for the 5-stage core. Each cycle it collects stall and redirect requests from the ID, EX and MEM stages and drives one `HoldFlagBus` code to every pipeline register and to the PC register. It queues an EX-stage jump that arrives while MEM is stalled and releases it once the stall clears. It also monitors the length of memory stalls and raises a sticky timeout.

---
 rtl/pipe_hold_ctrl_pkg.sv | 19 +
 rtl/pipe_hold_ctrl_stall_timer.sv | 39 +++
 rtl/pipe_hold_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hold_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hold_ctrl_pkg.sv
// Purpose: shared hold-flag codes and controller FSM encoding for the pipeline hold/flush logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hold_ctrl_pkg;

  // One code per pipeline register, the same for every register and the PC.
  typedef logic [2:0] hold_flag_bus_t;

  localparam hold_flag_bus_t HOLD_NONE  = 3'b000;  // register updates normally
  localparam hold_flag_bus_t HOLD_FLUSH = 3'b001;  // register loads its reset value
  localparam hold_flag_bus_t HOLD_HOLD  = 3'b010;  // register keeps its data

  // RUN: no jump queued. PEND: an EX jump arrived under a MEM stall and waits.
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hold_ctrl_stall_timer.sv
// Purpose: counts consecutive mem_wait cycles and raises a sticky timeout.
// Latency: stall_timeout registered; sets on the edge where the count reaches TIMEOUT.
// Backpressure: none; observes mem_wait only.
// Ports: clk, rst (async, active-low), mem_wait in, stall_timeout out.
module stall_timer #(
  parameter int CW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_wait,
  output logic stall_timeout
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  // Count value one edge before the timeout threshold is reached.
  localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT - 1);

  logic [CW-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      // Any cycle without a memory wait ends the stall run.
      if (!mem_wait) begin
        stall_cnt <= '0;
      end else if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      // Sticky: only reset clears it.
      if (mem_wait && (stall_cnt == CNT_PRE)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Purpose: central hold/flush controller; merges ID/EX/MEM stall and redirect requests into per-register hold flags.
// Latency: flags and redirect are combinational (0 cycles); FSM, pend_addr and stall timer update on clk.
// Backpressure: mem_wait > div_busy > redirect > load_use; a jump seen under mem_wait is queued until the stall clears.
// Ports: clk, rst (async, active-low); load_use_req, div_busy, jump_req, jump_addr, mem_wait in;
//        pc/ifid/idex/exmem/memwb_flag, redirect_valid, redirect_addr, stall_timeout out.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_use_req,
  input  logic           div_busy,
  input  logic           jump_req,
  input  logic [AW-1:0]  jump_addr,
  input  logic           mem_wait,
  output hold_flag_bus_t pc_flag,
  output hold_flag_bus_t ifid_flag,
  output hold_flag_bus_t idex_flag,
  output hold_flag_bus_t exmem_flag,
  output hold_flag_bus_t memwb_flag,
  output logic           redirect_valid,
  output logic [AW-1:0]  redirect_addr,
  output logic           stall_timeout
);

  state_t          state, state_nxt;
  logic [AW-1:0]   pend_addr, pend_addr_nxt;

  // State register. Reset drops any queued jump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  // Next state. In PEND a re-asserted jump_req is the same held EX
  // instruction, so the captured target is never overwritten.
  always_comb begin
    state_nxt     = state;
    pend_addr_nxt = pend_addr;
    case (state)
      RUN: begin
        if (mem_wait && jump_req) begin
          state_nxt     = PEND;
          pend_addr_nxt = jump_addr;
        end
      end
      PEND: begin
        if (!mem_wait && !div_busy) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output decode, highest priority first.
  always_comb begin
    pc_flag        = HOLD_NONE;
    ifid_flag      = HOLD_NONE;
    idex_flag      = HOLD_NONE;
    exmem_flag     = HOLD_NONE;
    memwb_flag     = HOLD_NONE;
    redirect_valid = 1'b0;
    redirect_addr  = jump_addr;
    if (mem_wait) begin
      // Freeze everything up to MEM; bubble into WB.
      pc_flag    = HOLD_HOLD;
      ifid_flag  = HOLD_HOLD;
      idex_flag  = HOLD_HOLD;
      exmem_flag = HOLD_HOLD;
      memwb_flag = HOLD_FLUSH;
    end else if (div_busy) begin
      // Jump from an unfinished EX op is not yet valid; ignore it.
      pc_flag    = HOLD_HOLD;
      ifid_flag  = HOLD_HOLD;
      idex_flag  = HOLD_HOLD;
      exmem_flag = HOLD_FLUSH;
    end else if ((state == PEND) || jump_req) begin
      // Redirect flushes the two wrong-path instructions; this also
      // overrides a load-use hazard on the flushed ID instruction.
      redirect_valid = 1'b1;
      redirect_addr  = (state == PEND) ? pend_addr : jump_addr;
      ifid_flag      = HOLD_FLUSH;
      idex_flag      = HOLD_FLUSH;
    end else if (load_use_req) begin
      pc_flag   = HOLD_HOLD;
      ifid_flag = HOLD_HOLD;
      idex_flag = HOLD_FLUSH;
    end
  end

  stall_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk           (clk),
    .rst           (rst),
    .mem_wait      (mem_wait),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Purpose: self-checking bench for pipe_hold_ctrl against a queue-based reference model.
// Latency: checks combinational outputs 1ns after the falling edge, state after each rising edge.
// Backpressure: n/a.
module tb_pipe_hold_ctrl;

  localparam int AW = 32;
  localparam int CW = 8;
  localparam int TO = 4;

  localparam logic [2:0] FN = 3'b000;
  localparam logic [2:0] FF = 3'b001;
  localparam logic [2:0] FH = 3'b010;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_use_req, div_busy, jump_req, mem_wait;
  logic [AW-1:0] jump_addr;
  logic [2:0]    pc_flag, ifid_flag, idex_flag, exmem_flag, memwb_flag;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          stall_timeout;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.AW(AW), .TIMEOUT(TO), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_req   (load_use_req),
    .div_busy       (div_busy),
    .jump_req       (jump_req),
    .jump_addr      (jump_addr),
    .mem_wait       (mem_wait),
    .pc_flag        (pc_flag),
    .ifid_flag      (ifid_flag),
    .idex_flag      (idex_flag),
    .exmem_flag     (exmem_flag),
    .memwb_flag     (memwb_flag),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall_timeout  (stall_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queued jump targets (0 or 1 entry), length of the
  // current memory-stall run, and the sticky timeout bit.
  logic [AW-1:0] m_pend_q[$];
  int            m_run;
  bit            m_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_pend_q.delete();
    m_run = 0;
    m_to  = 1'b0;
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic do_reset();
    @(negedge clk);
    load_use_req = 1'b0;
    div_busy     = 1'b0;
    jump_req     = 1'b0;
    mem_wait     = 1'b0;
    jump_addr    = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("rst_pc", {29'd0, pc_flag}, {29'd0, FN});
    chk("rst_memwb", {29'd0, memwb_flag}, {29'd0, FN});
    chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
    #1 rst = 1'b1;
    model_clear();
  endtask

  // One cycle: drive, check combinational outputs, then advance model at the edge.
  task automatic step(input bit lu, input bit db, input bit jr, input logic [31:0] ja, input bit mw);
    logic [2:0]  e [5];
    bit          erv;
    logic [31:0] ea;
    @(negedge clk);
    load_use_req = lu;
    div_busy     = db;
    jump_req     = jr;
    jump_addr    = ja;
    mem_wait     = mw;
    #1;
    erv = 1'b0;
    ea  = '0;
    e   = '{FN, FN, FN, FN, FN};
    if (mw) begin
      e = '{FH, FH, FH, FH, FF};
    end else if (db) begin
      e = '{FH, FH, FH, FF, FN};
    end else if (m_pend_q.size() != 0 || jr) begin
      erv = 1'b1;
      ea  = (m_pend_q.size() != 0) ? m_pend_q[0] : ja;
      e   = '{FN, FF, FF, FN, FN};
    end else if (lu) begin
      e = '{FH, FH, FF, FN, FN};
    end
    chk("pc_flag",    {29'd0, pc_flag},    {29'd0, e[0]});
    chk("ifid_flag",  {29'd0, ifid_flag},  {29'd0, e[1]});
    chk("idex_flag",  {29'd0, idex_flag},  {29'd0, e[2]});
    chk("exmem_flag", {29'd0, exmem_flag}, {29'd0, e[3]});
    chk("memwb_flag", {29'd0, memwb_flag}, {29'd0, e[4]});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, erv});
    if (erv) chk("redirect_addr", redirect_addr, ea);
    chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
    // Queue a jump seen under a memory stall; release once both stalls clear.
    if (m_pend_q.size() == 0) begin
      if (mw && jr) m_pend_q.push_back(ja);
    end else if (!mw && !db) begin
      void'(m_pend_q.pop_front());
    end
    if (mw) m_run++;
    else    m_run = 0;
    if (m_run == TO) m_to = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    load_use_req = 1'b0;
    div_busy     = 1'b0;
    jump_req     = 1'b0;
    mem_wait     = 1'b0;
    jump_addr    = '0;
    model_clear();
    do_reset();

    // Load-use bubble, then quiet.
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    // Jump in RUN.
    step(0, 0, 1, 32'h8000_0040, 0);
    step(0, 0, 0, 32'h0, 0);
    // Jump under a 3-cycle memory stall; re-asserted target ignored.
    step(0, 0, 1, 32'h100, 1);
    step(0, 0, 1, 32'h200, 1);
    step(0, 0, 1, 32'h200, 1);
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 32'h0, 0);
    // Divider stall swallows the jump.
    repeat (4) step(0, 1, 1, 32'h444, 0);
    step(0, 0, 0, 32'h0, 0);
    // mem_wait falls while div_busy is high: redirect deferred.
    step(0, 0, 1, 32'h500, 1);
    step(0, 1, 1, 32'h600, 0);
    step(0, 0, 1, 32'h600, 0);
    // Single-cycle memory stall with a jump.
    step(0, 0, 1, 32'h700, 1);
    step(0, 0, 1, 32'h700, 0);
    // Load-use with redirect: redirect wins.
    step(1, 0, 1, 32'h800, 0);
    // Timeout: 5-cycle stall, then sticky through a shorter one.
    repeat (5) step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    chk("timeout_sticky", {31'd0, stall_timeout}, 32'd1);
    repeat (3) step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 0);
    // Reset while in PEND drops the queued jump.
    step(0, 0, 1, 32'h300, 1);
    do_reset();
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) == 0,
             $urandom,
             $urandom_range(0, 2) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
